s3_feature_dispatch: RTL
========================

S3_FEATURE_DISPATCH -- requirements
Module: s3_feature_dispatch

Interface
REQ-001 SHALL have parameter CHUNK_LOG2, default 6: log2 of the features per core chunk (64).
REQ-002 SHALL have parameter N_CORE, default 64: maximum number of cores that can be dispatched per job.
REQ-003 SHALL have port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: one-cycle job request carrying the S3 partition result.
REQ-006 SHALL have port last_F, input, 12: first feature index of the S3 range (inclusive).
REQ-007 SHALL have port F3, input, 12: end feature index of the S3 range (exclusive).
REQ-008 SHALL have port disp_valid, output, 1: a chunk assignment is presented.
REQ-009 SHALL have port disp_ready, input, 1: the core array accepts the chunk.
REQ-010 SHALL have port core_id, output, 6: target core of the presented chunk.
REQ-011 SHALL have port f_begin, output, 12: first feature of the chunk (inclusive).
REQ-012 SHALL have port f_end, output, 12: end feature of the chunk (exclusive).
REQ-013 SHALL have port busy, output, 1: high from the accepted start until DONE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when the job completes.
REQ-015 SHALL have port core_used, output, 7: number of chunks issued in the last job, held until the next start.

Function
REQ-016 SHALL implement the states IDLE, ISSUE and DONE with one-hot or binary encoding.
REQ-017 SHALL, in IDLE with start=1, latch last_F and F3, clear the chunk counter, raise busy next cycle, and enter ISSUE (or DONE if last_F>=F3).
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL, in ISSUE, drive disp_valid=1, core_id=counter, f_begin=last_F+(counter<<CHUNK_LOG2), and f_end=min(f_begin+2^CHUNK_LOG2, F3), using 13-bit intermediate sums so no wrap occurs.
REQ-020 SHALL present the first chunk in the cycle after start is accepted (1-cycle latency).
REQ-021 SHALL hold core_id, f_begin and f_end stable while disp_valid=1 and disp_ready=0.
REQ-022 SHALL advance on disp_valid&&disp_ready: the counter increments, and the next chunk appears the following cycle with no bubble.
REQ-023 SHALL go to DONE after the handshake of the chunk whose f_end==F3, or after the handshake of chunk N_CORE-1, whichever comes first.
REQ-024 SHALL, in DONE, pulse done=1 for one cycle, load core_used, drop busy and disp_valid, and return to IDLE.
REQ-025 SHALL, for an empty range (last_F==F3), issue no chunk, pulse done two cycles after start, and set core_used=0.
REQ-026 SHALL allow a start in the cycle after DONE to be accepted.

Reset
REQ-027 SHALL, while rst_n=0, immediately force state=IDLE and drive disp_valid=0, busy=0, done=0, core_id=0, f_begin=0, f_end=0, core_used=0.
REQ-028 SHALL abort an in-flight job when reset is asserted mid-ISSUE, with no done pulse and no further chunks after release.

Configuration
REQ-029 SHALL, with S3_RANGE_CHECK_EN defined, add an output range_err (1 bit, reset 0), set in DONE when last_F>F3 or the range exceeds N_CORE<<CHUNK_LOG2 features, and cleared on the next accepted start; an erroring job SHALL issue no chunks.
REQ-030 SHALL, without S3_RANGE_CHECK_EN, have no range_err port, treat last_F>F3 as an empty range, and silently truncate at N_CORE chunks.

Verification
REQ-031 SHALL cover: last_F=0, F3=3703, disp_ready=1 -> 58 chunks, last chunk core 57 with f_begin=3648 and f_end=3703, core_used=58, done once.
REQ-032 SHALL cover: last_F=100, F3=150 -> 1 chunk (core 0, 100..150), core_used=1.
REQ-033 SHALL cover: last_F=F3=500 -> no disp_valid, done 2 cycles after start, core_used=0.
REQ-034 SHALL cover: disp_ready toggled randomly during a 0..300 job -> outputs stable while stalled, 5 chunks 0/64/128/192/256, last ends at 300.
REQ-035 SHALL cover: reset pulse after chunk 2 of the 0..3703 job -> all outputs 0 and IDLE, and a new start then runs cleanly.
REQ-036 SHALL cover: with S3_RANGE_CHECK_EN, last_F=200, F3=100 -> range_err=1, zero chunks, done pulse; a later valid start clears range_err.

Source files
------------

// File: rtl/s3_feature_dispatch.sv
// S3 feature-range dispatcher: splits [last_F, F3) into 2^CHUNK_LOG2-feature chunks, one per core.
// Optional macro S3_RANGE_CHECK_EN adds the range_err output and rejects malformed or oversized ranges.
module s3_feature_dispatch #(
  parameter int CHUNK_LOG2 = 6,
  parameter int N_CORE     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] last_F,
  input  logic [11:0] F3,
  output logic        disp_valid,
  input  logic        disp_ready,
  output logic [5:0]  core_id,
  output logic [11:0] f_begin,
  output logic [11:0] f_end,
  output logic        busy,
  output logic        done,
  output logic [6:0]  core_used
`ifdef S3_RANGE_CHECK_EN
  ,
  output logic        range_err
`endif
);

  localparam int          CHUNK     = 1 << CHUNK_LOG2;
  localparam logic [5:0]  LAST_CORE = 6'(N_CORE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t      state;
  logic [11:0] lo;
  logic [11:0] hi;
  logic [6:0]  issued;
  logic        empty;
  logic [11:0] first_end;
  logic [5:0]  next_id;
  logic [11:0] next_begin;
  logic [11:0] next_end;

  function automatic logic [11:0] chunk_begin(input logic [11:0] base, input logic [5:0] idx);
    return 12'({1'b0, base} + ({7'd0, idx} << CHUNK_LOG2));
  endfunction

  // End is clamped to the range limit; the 13-bit sum keeps the final chunk from wrapping.
  function automatic logic [11:0] chunk_end(input logic [11:0] base, input logic [5:0] idx,
                                            input logic [11:0] lim);
    logic [12:0] b;
    logic [12:0] e;
    b = {1'b0, base} + ({7'd0, idx} << CHUNK_LOG2);
    e = b + 13'(CHUNK);
    return (e > {1'b0, lim}) ? lim : e[11:0];
  endfunction

`ifdef S3_RANGE_CHECK_EN
  localparam int SPAN_MAX = N_CORE << CHUNK_LOG2;
  logic [12:0] span;
  logic        bad;
  logic        err_pend;
  assign span  = {1'b0, F3} - {1'b0, last_F};
  assign bad   = (last_F > F3) || (int'(span) > SPAN_MAX);
  assign empty = (last_F >= F3) || bad;
`else
  assign empty = (last_F >= F3);
`endif

  assign first_end  = chunk_end(last_F, 6'd0, F3);
  assign next_id    = core_id + 6'd1;
  assign next_begin = chunk_begin(lo, next_id);
  assign next_end   = chunk_end(lo, next_id, hi);

  // Range bounds only matter while a job is active, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      lo <= last_F;
      hi <= F3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      core_id    <= 6'd0;
      f_begin    <= 12'd0;
      f_end      <= 12'd0;
      core_used  <= 7'd0;
      issued     <= 7'd0;
`ifdef S3_RANGE_CHECK_EN
      range_err  <= 1'b0;
      err_pend   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            issued  <= 7'd0;
            core_id <= 6'd0;
`ifdef S3_RANGE_CHECK_EN
            range_err <= 1'b0;
            err_pend  <= bad;
`endif
            if (empty) begin
              state <= DONE;
            end else begin
              state      <= ISSUE;
              disp_valid <= 1'b1;
              f_begin    <= last_F;
              f_end      <= first_end;
            end
          end
        end
        ISSUE: begin
          // The next chunk is loaded on the accepting edge, so back-to-back accepts have no bubble.
          if (disp_ready) begin
            issued <= issued + 7'd1;
            if (f_end == hi || core_id == LAST_CORE) begin
              state      <= DONE;
              disp_valid <= 1'b0;
            end else begin
              core_id <= next_id;
              f_begin <= next_begin;
              f_end   <= next_end;
            end
          end
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          core_used <= issued;
          state     <= IDLE;
`ifdef S3_RANGE_CHECK_EN
          range_err <= err_pend;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
